stp_coef_loader: RTL and testbench

Upstream neighbour of the polynomial evaluator: executes the "store polynomial" (STP) command.
- Latches vector index A and degree N, pops N+1 coefficient tokens from a first-word-fall-through (FWFT) input FIFO, and writes them into the coefficient RAM (vec = A, coef = 0..N).
- Commits N into the N RAM last, so the evaluator never sees a partially loaded polynomial.
- Reports status and pulses done to the top-level controller.

---
 rtl/evp_pkg.sv | 37 +++
 rtl/stp_watchdog.sv | 35 +++
 rtl/stp_coef_loader.sv | 155 +++++++++++++++
 tb/tb_stp_coef_loader.sv | 457 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/evp_pkg.sv
// Shared definitions for the polynomial load/evaluate datapath.
// Holds the STP FSM encoding, status codes and the invalid-degree marker.
package evp_pkg;

    localparam int MAX_DEG = 10;

    localparam logic [4:0] INVALID_N = 5'h1F;

    localparam logic [31:0] STATUS_OK      = 32'd0;
    localparam logic [31:0] STATUS_BAD_DEG = 32'd2;
    localparam logic [31:0] STATUS_TIMEOUT = 32'd3;
    localparam logic [31:0] STATUS_IDLE    = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_INVAL,
        S_LOAD,
        S_DRAIN,
        S_COMMIT,
        S_ERROR,
        S_END
    } stp_state_t;

    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            w = w + 1;
        end
        if (w == 0) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/stp_watchdog.sv
// Starvation counter for the STP loader, built only with STP_TIMEOUT_EN.
// Counts consecutive empty-FIFO cycles while the loader waits for tokens.
`ifdef STP_TIMEOUT_EN
module stp_watchdog
    import evp_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic fifo_empty,
    output logic timeout
);

    localparam int CW = clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] starve_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!active || !fifo_empty) begin
            starve_cnt <= '0;
        end else if (starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Fires on the TIMEOUT_CYCLES-th consecutive empty cycle.
    assign timeout = active && fifo_empty && (starve_cnt == LIMIT);

endmodule
`endif

// File: rtl/stp_coef_loader.sv
// STP command engine: streams N+1 FIFO coefficients into the coefficient RAM
// and commits the degree last. Optional starvation watchdog: STP_TIMEOUT_EN.
module stp_coef_loader #(
    parameter int COEF_WIDTH     = 16,
    parameter int N_WIDTH        = 5,
    parameter int MAX_DEG        = evp_pkg::MAX_DEG,
    parameter int VEC_ADDR_WIDTH = 3,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_stp,
    input  logic [VEC_ADDR_WIDTH-1:0] A,
    input  logic [N_WIDTH-1:0]        N_in,
    input  logic                      fifo_empty,
    input  logic [COEF_WIDTH-1:0]     fifo_dout,
    output logic                      fifo_rd_en,
    output logic                      wr_en_S,
    output logic [VEC_ADDR_WIDTH-1:0] wr_addr_S_vec,
    output logic [3:0]                wr_addr_S_coef,
    output logic [COEF_WIDTH-1:0]     wr_data_S,
    output logic                      wr_en_N,
    output logic [VEC_ADDR_WIDTH-1:0] wr_addr_N,
    output logic [N_WIDTH-1:0]        wr_data_N,
    output logic                      done_stp,
    output logic [31:0]               status
);

    import evp_pkg::*;

    localparam logic [N_WIDTH-1:0] MAX_N = N_WIDTH'(MAX_DEG);
    localparam logic [N_WIDTH-1:0] INV_N = N_WIDTH'(INVALID_N);

    stp_state_t                state;
    logic [VEC_ADDR_WIDTH-1:0] vec_r;
    logic [N_WIDTH-1:0]        n_r;
    logic [N_WIDTH-1:0]        cnt;
    logic [31:0]               err_r;
    logic                      busy;
    logic                      last;
    logic                      timeout;

    assign busy       = (state == S_LOAD) || (state == S_DRAIN);
    assign fifo_rd_en = busy && !fifo_empty;
    assign last       = (cnt == n_r);

`ifdef STP_TIMEOUT_EN
    stp_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .active    (busy),
        .fifo_empty(fifo_empty),
        .timeout   (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            vec_r          <= '0;
            n_r            <= '0;
            cnt            <= '0;
            err_r          <= STATUS_IDLE;
            wr_en_S        <= 1'b0;
            wr_addr_S_vec  <= '0;
            wr_addr_S_coef <= '0;
            wr_data_S      <= '0;
            wr_en_N        <= 1'b0;
            wr_addr_N      <= '0;
            wr_data_N      <= '0;
            done_stp       <= 1'b0;
            status         <= STATUS_IDLE;
        end else begin
            wr_en_S  <= 1'b0;
            wr_en_N  <= 1'b0;
            done_stp <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start_stp) begin
                        state <= S_START;
                    end
                end
                S_START: begin
                    vec_r  <= A;
                    n_r    <= N_in;
                    cnt    <= '0;
                    status <= STATUS_IDLE;
                    state  <= S_INVAL;
                end
                // Invalidate first so a half-loaded vector is never usable.
                S_INVAL: begin
                    wr_en_N   <= 1'b1;
                    wr_addr_N <= vec_r;
                    wr_data_N <= INV_N;
                    if (n_r > MAX_N) begin
                        err_r <= STATUS_BAD_DEG;
                        state <= S_DRAIN;
                    end else begin
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (fifo_rd_en) begin
                        wr_en_S        <= 1'b1;
                        wr_addr_S_vec  <= vec_r;
                        wr_addr_S_coef <= cnt[3:0];
                        wr_data_S      <= fifo_dout;
                        cnt            <= cnt + 1'b1;
                        if (last) begin
                            state <= S_COMMIT;
                        end
                    end else if (timeout) begin
                        err_r <= STATUS_TIMEOUT;
                        state <= S_ERROR;
                    end
                end
                // Bad degree: consume the tokens anyway to keep the stream aligned.
                S_DRAIN: begin
                    if (fifo_rd_en) begin
                        cnt <= cnt + 1'b1;
                        if (last) begin
                            state <= S_ERROR;
                        end
                    end else if (timeout) begin
                        err_r <= STATUS_TIMEOUT;
                        state <= S_ERROR;
                    end
                end
                S_COMMIT: begin
                    wr_en_N   <= 1'b1;
                    wr_addr_N <= vec_r;
                    wr_data_N <= n_r;
                    status    <= STATUS_OK;
                    state     <= S_END;
                end
                S_ERROR: begin
                    status <= err_r;
                    state  <= S_END;
                end
                S_END: begin
                    done_stp <= 1'b1;
                    state    <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stp_coef_loader.sv
// Self-checking bench for stp_coef_loader: FIFO model plus ordered
// scoreboard of expected S/N RAM writes. Define STP_TIMEOUT_EN for timeout test.
module tb_stp_coef_loader;

    logic        clk;
    logic        rst;
    logic        start_stp;
    logic [2:0]  A;
    logic [4:0]  N_in;
    logic        fifo_empty;
    logic [15:0] fifo_dout;
    logic        fifo_rd_en;
    logic        wr_en_S;
    logic [2:0]  wr_addr_S_vec;
    logic [3:0]  wr_addr_S_coef;
    logic [15:0] wr_data_S;
    logic        wr_en_N;
    logic [2:0]  wr_addr_N;
    logic [4:0]  wr_data_N;
    logic        done_stp;
    logic [31:0] status;

    int checks = 0;
    int errors = 0;

    logic [15:0] fifo_q[$];
    logic [23:0] exp_q[$];
    logic [4:0]  n_ram[8];
    bit          pop_s;

    stp_coef_loader #(
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_stp     (start_stp),
        .A             (A),
        .N_in          (N_in),
        .fifo_empty    (fifo_empty),
        .fifo_dout     (fifo_dout),
        .fifo_rd_en    (fifo_rd_en),
        .wr_en_S       (wr_en_S),
        .wr_addr_S_vec (wr_addr_S_vec),
        .wr_addr_S_coef(wr_addr_S_coef),
        .wr_data_S     (wr_data_S),
        .wr_en_N       (wr_en_N),
        .wr_addr_N     (wr_addr_N),
        .wr_data_N     (wr_data_N),
        .done_stp      (done_stp),
        .status        (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] s_ent(input logic [2:0] v,
                                          input logic [3:0] c,
                                          input logic [15:0] d);
        return {1'b0, v, c, d};
    endfunction

    function automatic logic [23:0] n_ent(input logic [2:0] v,
                                          input logic [4:0] n);
        return {1'b1, v, 4'd0, 11'd0, n};
    endfunction

    task automatic fifo_refresh();
        fifo_empty = (fifo_q.size() == 0);
        fifo_dout  = (fifo_q.size() != 0) ? fifo_q[0] : 16'h0000;
    endtask

    task automatic fifo_push(input logic [15:0] d);
        fifo_q.push_back(d);
        fifo_refresh();
    endtask

    // FIFO model: pop the head a little after the edge that consumed it.
    always @(posedge clk) begin
        pop_s = fifo_rd_en;
        #1;
        if (pop_s && fifo_q.size() != 0) begin
            void'(fifo_q.pop_front());
        end
        fifo_refresh();
    end

    // Write monitor: every RAM write must match the scoreboard head, in order.
    always @(negedge clk) begin
        logic [23:0] obs;
        logic [23:0] e;
        if (!rst) begin
            if (wr_en_S && wr_en_N) begin
                checks++;
                errors++;
                $display("FAIL both_we: wr_en_S=1 wr_en_N=1, required not both");
            end
            if (wr_en_S && wr_addr_S_coef > 4'd10) begin
                checks++;
                errors++;
                $display("FAIL coef_bound: coef=%0d, required <= 10", wr_addr_S_coef);
            end
            if (wr_en_S || wr_en_N) begin
                obs = wr_en_N ? {1'b1, wr_addr_N, 4'd0, 11'd0, wr_data_N}
                              : {1'b0, wr_addr_S_vec, wr_addr_S_coef, wr_data_S};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: got %h, required none", obs);
                end else begin
                    e = exp_q.pop_front();
                    if (obs !== e) begin
                        errors++;
                        $display("FAIL write_seq: got %h, required %h", obs, e);
                    end
                end
                if (wr_en_N) begin
                    n_ram[wr_addr_N] = wr_data_N;
                end
            end
        end
    end

    task automatic start_cmd(input logic [2:0] a, input logic [4:0] n);
        @(posedge clk);
        #1;
        A         = a;
        N_in      = n;
        start_stp = 1'b1;
        @(posedge clk);
        #1;
        start_stp = 1'b0;
    endtask

    // cyc counts clock edges from the one that sampled start_stp.
    task automatic wait_done(input int limit, output int cyc, output bit ok);
        cyc = 1;
        ok  = 1'b0;
        while (cyc < limit && !ok) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done_stp) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({wr_en_S, wr_en_N, fifo_rd_en, done_stp} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, required 0000",
                     {wr_en_S, wr_en_N, fifo_rd_en, done_stp});
        end
        checks++;
        if ({wr_addr_S_vec, wr_addr_S_coef, wr_data_S, wr_addr_N, wr_data_N} !== 31'd0) begin
            errors++;
            $display("FAIL reset_data: got %h, required 0",
                     {wr_addr_S_vec, wr_addr_S_coef, wr_data_S, wr_addr_N, wr_data_N});
        end
        checks++;
        if (status !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL reset_status: got %h, required ffffffff", status);
        end
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    task automatic test_reset_wins();
        int cyc;
        bit ok;
        @(posedge clk);
        #1;
        rst       = 1'b1;
        start_stp = 1'b1;
        A         = 3'd7;
        N_in      = 5'd1;
        @(posedge clk);
        #1;
        start_stp = 1'b0;
        rst       = 1'b0;
        wait_done(12, cyc, ok);
        checks++;
        if (ok !== 1'b0 || status !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL reset_wins: done=%0d status=%h, required no done, ffffffff",
                     ok, status);
        end
    endtask

    task automatic test_basic();
        int cyc;
        bit ok;
        fifo_push(16'd5);
        fifo_push(16'd7);
        fifo_push(16'd9);
        fifo_push(16'hAAAA);
        exp_q.push_back(n_ent(3'd3, 5'h1F));
        exp_q.push_back(s_ent(3'd3, 4'd0, 16'd5));
        exp_q.push_back(s_ent(3'd3, 4'd1, 16'd7));
        exp_q.push_back(s_ent(3'd3, 4'd2, 16'd9));
        exp_q.push_back(n_ent(3'd3, 5'd2));
        start_cmd(3'd3, 5'd2);
        wait_done(40, cyc, ok);
        checks++;
        if (!ok || cyc != 8) begin
            errors++;
            $display("FAIL basic_latency: done=%0d cycles=%0d, required 8", ok, cyc);
        end
        checks++;
        if (status !== 32'd0) begin
            errors++;
            $display("FAIL basic_status: got %h, required 0", status);
        end
        checks++;
        if (exp_q.size() != 0 || n_ram[3] !== 5'd2) begin
            errors++;
            $display("FAIL basic_writes: pending=%0d N3=%h, required 0, 02",
                     exp_q.size(), n_ram[3]);
        end
        checks++;
        if (fifo_q.size() != 1) begin
            errors++;
            $display("FAIL basic_pops: left=%0d, required 1", fifo_q.size());
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (done_stp !== 1'b0 || status !== 32'd0) begin
            errors++;
            $display("FAIL basic_hold: done=%b status=%h, required 0, 0", done_stp, status);
        end
        fifo_q.delete();
        fifo_refresh();
    endtask

    task automatic test_max_deg();
        int cyc;
        bit ok;
        exp_q.push_back(n_ent(3'd0, 5'h1F));
        for (int i = 0; i < 11; i++) begin
            fifo_push(16'(i + 1));
            exp_q.push_back(s_ent(3'd0, 4'(i), 16'(i + 1)));
        end
        fifo_push(16'd99);
        exp_q.push_back(n_ent(3'd0, 5'd10));
        start_cmd(3'd0, 5'd10);
        @(posedge clk);
        #1;
        checks++;
        if (status !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL max_status_clear: got %h, required ffffffff", status);
        end
        wait_done(60, cyc, ok);
        checks++;
        if (!ok || status !== 32'd0) begin
            errors++;
            $display("FAIL max_done: done=%0d status=%h, required 1, 0", ok, status);
        end
        checks++;
        if (exp_q.size() != 0 || n_ram[0] !== 5'd10 || fifo_q.size() != 1) begin
            errors++;
            $display("FAIL max_writes: pending=%0d N0=%h left=%0d, required 0, 0a, 1",
                     exp_q.size(), n_ram[0], fifo_q.size());
        end
        fifo_q.delete();
        fifo_refresh();
    endtask

    task automatic test_bad_deg();
        int cyc;
        bit ok;
        for (int i = 0; i < 13; i++) begin
            fifo_push(16'(16'h100 + i));
        end
        exp_q.push_back(n_ent(3'd5, 5'h1F));
        start_cmd(3'd5, 5'd12);
        wait_done(60, cyc, ok);
        checks++;
        if (!ok || status !== 32'd2) begin
            errors++;
            $display("FAIL bad_status: done=%0d status=%h, required 1, 2", ok, status);
        end
        checks++;
        if (fifo_q.size() != 0 || exp_q.size() != 0 || n_ram[5] !== 5'h1F) begin
            errors++;
            $display("FAIL bad_drain: left=%0d pending=%0d N5=%h, required 0, 0, 1f",
                     fifo_q.size(), exp_q.size(), n_ram[5]);
        end
    endtask

    task automatic test_gap();
        int cyc;
        int w;
        bit ok;
        bit bad;
        fifo_push(16'd11);
        fifo_push(16'd22);
        exp_q.push_back(n_ent(3'd1, 5'h1F));
        exp_q.push_back(s_ent(3'd1, 4'd0, 16'd11));
        exp_q.push_back(s_ent(3'd1, 4'd1, 16'd22));
        exp_q.push_back(s_ent(3'd1, 4'd2, 16'd33));
        exp_q.push_back(s_ent(3'd1, 4'd3, 16'd44));
        exp_q.push_back(n_ent(3'd1, 5'd3));
        start_cmd(3'd1, 5'd3);
        w = 0;
        while (fifo_q.size() != 0 && w < 20) begin
            @(posedge clk);
            #2;
            w++;
        end
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #2;
            if (wr_en_S !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad || w >= 20) begin
            errors++;
            $display("FAIL gap_stall: write_in_gap=%0d waited=%0d, required 0, <20", bad, w);
        end
        fifo_push(16'd33);
        fifo_push(16'd44);
        wait_done(30, cyc, ok);
        checks++;
        if (!ok || status !== 32'd0 || exp_q.size() != 0 || n_ram[1] !== 5'd3) begin
            errors++;
            $display("FAIL gap_result: done=%0d status=%h pending=%0d N1=%h, required 1, 0, 0, 03",
                     ok, status, exp_q.size(), n_ram[1]);
        end
    endtask

    task automatic test_reset_mid_load();
        int cyc;
        int w;
        bit ok;
        exp_q.push_back(n_ent(3'd2, 5'h1F));
        for (int i = 0; i < 5; i++) begin
            fifo_push(16'(100 + i));
            exp_q.push_back(s_ent(3'd2, 4'(i), 16'(100 + i)));
        end
        exp_q.push_back(n_ent(3'd2, 5'd4));
        start_cmd(3'd2, 5'd4);
        w = 0;
        while (!(wr_en_S && wr_addr_S_coef == 4'd1) && w < 20) begin
            @(posedge clk);
            #1;
            w++;
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({wr_en_S, wr_en_N, fifo_rd_en, done_stp, wr_data_S} !== 20'd0 || w >= 20) begin
            errors++;
            $display("FAIL midrst_outputs: ctrl=%b data=%h waited=%0d, required 0, 0, <20",
                     {wr_en_S, wr_en_N, fifo_rd_en, done_stp}, wr_data_S, w);
        end
        checks++;
        if (status !== 32'hFFFF_FFFF || n_ram[2] !== 5'h1F) begin
            errors++;
            $display("FAIL midrst_state: status=%h N2=%h, required ffffffff, 1f",
                     status, n_ram[2]);
        end
        exp_q.delete();
        fifo_q.delete();
        fifo_refresh();
        @(posedge clk);
        #3;
        rst = 1'b0;
        fifo_push(16'hBEEF);
        exp_q.push_back(n_ent(3'd2, 5'h1F));
        exp_q.push_back(s_ent(3'd2, 4'd0, 16'hBEEF));
        exp_q.push_back(n_ent(3'd2, 5'd0));
        start_cmd(3'd2, 5'd0);
        wait_done(30, cyc, ok);
        checks++;
        if (!ok || cyc != 6 || status !== 32'd0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL midrst_restart: done=%0d cycles=%0d status=%h pending=%0d, required 1, 6, 0, 0",
                     ok, cyc, status, exp_q.size());
        end
    endtask

`ifdef STP_TIMEOUT_EN
    task automatic test_timeout();
        int cyc;
        bit ok;
        fifo_push(16'h1234);
        exp_q.push_back(n_ent(3'd4, 5'h1F));
        exp_q.push_back(s_ent(3'd4, 4'd0, 16'h1234));
        start_cmd(3'd4, 5'd3);
        wait_done(60, cyc, ok);
        checks++;
        if (!ok || cyc != 22 || status !== 32'd3) begin
            errors++;
            $display("FAIL timeout: done=%0d cycles=%0d status=%h, required 1, 22, 3",
                     ok, cyc, status);
        end
        checks++;
        if (n_ram[4] !== 5'h1F || exp_q.size() != 0) begin
            errors++;
            $display("FAIL timeout_n: N4=%h pending=%0d, required 1f, 0", n_ram[4], exp_q.size());
        end
    endtask
`else
    task automatic test_no_timeout();
        int cyc;
        bit ok;
        exp_q.push_back(n_ent(3'd6, 5'h1F));
        exp_q.push_back(s_ent(3'd6, 4'd0, 16'h0ABC));
        exp_q.push_back(n_ent(3'd6, 5'd0));
        start_cmd(3'd6, 5'd0);
        wait_done(40, cyc, ok);
        checks++;
        if (ok !== 1'b0 || status !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL starve_wait: done=%0d status=%h, required 0, ffffffff", ok, status);
        end
        fifo_push(16'h0ABC);
        wait_done(10, cyc, ok);
        checks++;
        if (!ok || status !== 32'd0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL starve_resume: done=%0d status=%h pending=%0d, required 1, 0, 0",
                     ok, status, exp_q.size());
        end
    endtask
`endif

    initial begin
        rst       = 1'b1;
        start_stp = 1'b0;
        A         = '0;
        N_in      = '0;
        for (int i = 0; i < 8; i++) n_ram[i] = 5'd0;
        fifo_refresh();
        test_reset();
        test_reset_wins();
        test_basic();
        test_max_deg();
        test_bad_deg();
        test_gap();
        test_reset_mid_load();
`ifdef STP_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
